// File: rtl/mmio_uart_pkg.sv
// Shared register offsets, access sizes, status bit positions and shifter
// states for the memory-mapped UART transmitter.
package mmio_uart_pkg;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int unsigned STAT_FULL    = 0;
   localparam int unsigned STAT_EMPTY   = 1;
   localparam int unsigned STAT_BUSY    = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_e;

   // Encoding 2'b11 is treated as a word access as well.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path; DEPTH must be a power of 2.
// A push while full is dropped, judged before any same-cycle pop.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, status/baud/control registers.
// Optional macro UART_TX_IRQ_EN adds the irq output and CTRL.irq_en bit.
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic [1:0]  mem_size,
   output logic [31:0] rd,
   output logic        txd
`ifdef UART_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e   state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [15:0] div_q, div_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        txd_q, txd_d;
   logic        en_q, en_d;
   logic        ovf_q, ovf_d;
`ifdef UART_TX_IRQ_EN
   logic        irq_en_q, irq_en_d;
   logic        irq_q, irq_d;
`endif

   logic          wr_hit, word_wr, push, pop, busy;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic [3:0]    status_cnt;
   logic          unused_bits;

   assign wr_hit      = sel & we;
   assign word_wr     = wr_hit & is_word(mem_size);
   assign push        = wr_hit & (addr[3:2] == REG_TXDATA);
   assign busy        = (state_q != ST_IDLE);
   assign status_cnt  = 4'(fifo_count);
   assign txd         = txd_q;
   assign unused_bits = ^{addr[31:4], addr[1:0], wd[31:16]};

   uart_tx_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(8)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .wdata(wd[7:0]),
      .pop  (pop),
      .rdata(fifo_rdata),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   // The STOP bit hands straight over to the next START when data is waiting.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_q && !fifo_empty) begin
               pop        = 1'b1;
               shift_d    = fifo_rdata;
               baud_cnt_d = div_q;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            if (baud_cnt_q == '0) begin
               baud_cnt_d = div_q;
               bit_idx_d  = '0;
               state_d    = ST_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_cnt_q == '0) begin
               baud_cnt_d = div_q;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         ST_STOP: begin
            if (baud_cnt_q == '0) begin
               if (en_q && !fifo_empty) begin
                  pop        = 1'b1;
                  shift_d    = fifo_rdata;
                  baud_cnt_d = div_q;
                  state_d    = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      txd_d = 1'b1;
      if (state_d == ST_START)     txd_d = 1'b0;
      else if (state_d == ST_DATA) txd_d = shift_d[0];
   end

   always_comb begin
      div_d = div_q;
      en_d  = en_q;
      ovf_d = ovf_q;
`ifdef UART_TX_IRQ_EN
      irq_en_d = irq_en_q;
      irq_d    = irq_en_q & fifo_empty & ~busy;
`endif
      if (push && fifo_full) ovf_d = 1'b1;
      if (word_wr) begin
         case (addr[3:2])
            REG_STATUS:  if (wd[STAT_OVF]) ovf_d = 1'b0;
            REG_BAUDDIV: div_d = wd[15:0];
            REG_CTRL: begin
               en_d = wd[0];
`ifdef UART_TX_IRQ_EN
               irq_en_d = wd[1];
`endif
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd = '0;
      if (sel) begin
         case (addr[3:2])
            REG_STATUS: begin
               rd[STAT_FULL]          = fifo_full;
               rd[STAT_EMPTY]         = fifo_empty;
               rd[STAT_BUSY]          = busy;
               rd[STAT_OVF]           = ovf_q;
               rd[STAT_CNT_LSB +: 4]  = status_cnt;
            end
            REG_BAUDDIV: rd[15:0] = div_q;
            REG_CTRL: begin
               rd[0] = en_q;
`ifdef UART_TX_IRQ_EN
               rd[1] = irq_en_q;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
         div_q      <= DEFAULT_DIV;
         en_q       <= 1'b1;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         div_q      <= div_d;
         en_q       <= en_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef UART_TX_IRQ_EN
   assign irq = irq_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-level model compared every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_mmio_uart_tx;

   localparam int          DEPTH = 8;
   localparam logic [15:0] DDIV  = 16'd867;
   localparam logic [1:0]  SZ_B  = 2'b00;
   localparam logic [1:0]  SZ_H  = 2'b01;
   localparam logic [1:0]  SZ_W  = 2'b10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wd = '0;
   logic [1:0]  mem_size = SZ_W;
   logic [31:0] rd;
   logic        txd;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mmio_uart_tx #(
      .FIFO_DEPTH(DEPTH),
      .DEFAULT_DIV(DDIV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .we      (we),
      .addr    (addr),
      .wd      (wd),
      .mem_size(mem_size),
      .rd      (rd),
      .txd     (txd)
`ifdef UART_TX_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   always #5 clk = ~clk;

   // Frame-level model: byte queue plus the line image of the frame in flight.
   logic [7:0]  m_q[$];
   logic        m_valid = 1'b0;
   logic        m_ovf, m_en, m_active;
   logic [15:0] m_div;
   logic [9:0]  m_frame;
   int          m_t, m_blen;
`ifdef UART_TX_IRQ_EN
   logic        m_irq_en, m_irq;
`endif

   always @(posedge clk) begin : model
      bit   full_b, pushing, wordw;
`ifdef UART_TX_IRQ_EN
      logic irq_n;
`endif
      if (rst) begin
         m_q.delete();
         m_ovf    = 1'b0;
         m_en     = 1'b1;
         m_div    = DDIV;
         m_active = 1'b0;
         m_t      = 0;
         m_blen   = 1;
         m_frame  = '1;
         m_valid  = 1'b1;
`ifdef UART_TX_IRQ_EN
         m_irq_en = 1'b0;
         m_irq    = 1'b0;
`endif
      end else if (m_valid) begin
`ifdef UART_TX_IRQ_EN
         irq_n = m_irq_en && (m_q.size() == 0) && !m_active;
`endif
         full_b  = (m_q.size() == DEPTH);
         pushing = sel && we && (addr[3:2] == 2'd0);
         wordw   = sel && we && mem_size[1];
         if (m_active) begin
            m_t++;
            if (m_t == 10 * m_blen) m_active = 1'b0;
         end
         if (!m_active && m_en && m_q.size() > 0) begin
            m_frame  = {1'b1, m_q.pop_front(), 1'b0};
            m_blen   = int'(m_div) + 1;
            m_t      = 0;
            m_active = 1'b1;
         end
         if (pushing) begin
            if (full_b) m_ovf = 1'b1;
            else        m_q.push_back(wd[7:0]);
         end
         if (wordw && addr[3:2] == 2'd1 && wd[3]) m_ovf = 1'b0;
         if (wordw && addr[3:2] == 2'd2) m_div = wd[15:0];
         if (wordw && addr[3:2] == 2'd3) begin
            m_en = wd[0];
`ifdef UART_TX_IRQ_EN
            m_irq_en = wd[1];
`endif
         end
`ifdef UART_TX_IRQ_EN
         m_irq = irq_n;
`endif
      end
   end

   function automatic logic exp_txd();
      if (!m_active) return 1'b1;
      return m_frame[m_t / m_blen];
   endfunction

   function automatic logic [31:0] exp_rd();
      logic [31:0] r = '0;
      if (!sel) return '0;
      case (addr[3:2])
         2'd1: begin
            r[0]    = (m_q.size() == DEPTH);
            r[1]    = (m_q.size() == 0);
            r[2]    = m_active;
            r[3]    = m_ovf;
            r[11:8] = 4'(m_q.size());
         end
         2'd2: r[15:0] = m_div;
         2'd3: begin
            r[0] = m_en;
`ifdef UART_TX_IRQ_EN
            r[1] = m_irq_en;
`endif
         end
         default: ;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("txd_vs_model", {31'd0, txd}, {31'd0, exp_txd()});
         check("rd_vs_model", rd, exp_rd());
`ifdef UART_TX_IRQ_EN
         check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      sel = 1'b1; we = 1'b1; addr = a; wd = d; mem_size = sz;
      @(posedge clk);
      #1;
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      sel = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      d = rd;
      @(posedge clk);
      #1;
      sel = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   logic [31:0] v;
   logic [9:0]  a5_line = 10'b1101001010;  // time order from bit 0: start, A5 LSB first, stop
   logic        tx_s [0:129];
   logic [31:0] st_s [0:129];
   int          busy_n, first_busy, last_busy;
`ifdef UART_TX_IRQ_EN
   logic        irq_s [0:14];
`endif

   task automatic monitor_status(input int n);
      sel = 1'b1; we = 1'b0; addr = 32'h4;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tx_s[i] = txd;
         st_s[i] = rd;
`ifdef UART_TX_IRQ_EN
         if (i < 15) irq_s[i] = irq;
`endif
      end
      @(posedge clk);
      #1;
      sel = 1'b0;
      busy_n = 0; first_busy = -1; last_busy = -1;
      for (int i = 0; i < n; i++) begin
         if (st_s[i][2]) begin
            busy_n++;
            if (first_busy < 0) first_busy = i;
            last_busy = i;
         end
      end
   endtask

   initial begin
      // Reset
      do_reset();
      check("reset_txd", {31'd0, txd}, 32'd1);
      bus_read(32'h4, v); check("reset_status", v, 32'h0000_0002);
      bus_read(32'h8, v); check("reset_bauddiv", v, 32'd867);
      bus_read(32'hC, v); check("reset_ctrl", v, 32'd1);

      // Single 0xA5 frame at BAUDDIV=3
      bus_write(32'h8, 32'd3, SZ_W);
      bus_write(32'h0, 32'hA5, SZ_B);
      monitor_status(42);
      check("a5_pre_start_txd", {31'd0, tx_s[0]}, 32'd1);
      check("a5_pre_start_status", st_s[0], 32'h0000_0100);
      for (int k = 0; k < 10; k++)
         check($sformatf("a5_bit%0d", k), {31'd0, tx_s[4*k+2]}, {31'd0, a5_line[k]});
      check("a5_busy_cycles", busy_n, 32'd40);
      check("a5_end_status", st_s[41], 32'h0000_0002);

      // Three queued bytes released by enable: back-to-back frames
      bus_write(32'hC, 32'd0, SZ_W);
      bus_write(32'h0, 32'h01, SZ_B);
      bus_write(32'h0, 32'h02, SZ_B);
      bus_write(32'h0, 32'h03, SZ_B);
      bus_write(32'hC, 32'd1, SZ_W);
      monitor_status(130);
      check("b2b_status_before_pop", st_s[0], 32'h0000_0300);
      check("b2b_count_after_pop", {28'd0, st_s[1][11:8]}, 32'd2);
      check("b2b_first_busy", first_busy, 32'd1);
      check("b2b_last_busy", last_busy, 32'd120);
      check("b2b_busy_cycles", busy_n, 32'd120);
      check("b2b_stop1_txd", {31'd0, tx_s[40]}, 32'd1);
      check("b2b_start2_txd", {31'd0, tx_s[41]}, 32'd0);

      // Overflow with the shifter disabled
      bus_write(32'hC, 32'd0, SZ_W);
      for (int i = 0; i < 9; i++) bus_write(32'h0, 32'h10 + i, SZ_B);
      bus_read(32'h4, v); check("ovf_status", v, 32'h0000_0809);
      bus_write(32'h4, 32'h8, SZ_B);
      bus_read(32'h4, v); check("ovf_subword_w1c_ignored", v, 32'h0000_0809);
      bus_write(32'h4, 32'h8, SZ_W);
      bus_read(32'h4, v); check("ovf_cleared", v, 32'h0000_0801);

      // Access-size rules and deselected reads
      do_reset();
      bus_write(32'h8, 32'hFFFF, SZ_B);
      bus_read(32'h8, v); check("baud_byte_ignored", v, 32'd867);
      bus_write(32'h8, 32'hFFFF, SZ_W);
      bus_read(32'h8, v); check("baud_word_written", v, 32'h0000_FFFF);
      bus_write(32'hC, 32'd0, SZ_H);
      bus_read(32'hC, v); check("ctrl_half_ignored", v, 32'd1);
      bus_read(32'h0, v); check("txdata_reads_zero", v, 32'd0);
      sel = 1'b0; addr = 32'h8;
      @(negedge clk);
      check("rd_unselected", rd, 32'd0);
      tick(1);

      // Reset in the middle of DATA bit 4 discards the frame and the FIFO
      do_reset();
      bus_write(32'h8, 32'd3, SZ_W);
      bus_write(32'h0, 32'h5A, SZ_B);
      bus_write(32'h0, 32'h33, SZ_B);
      tick(21);
      rst = 1'b1; sel = 1'b1; we = 1'b0; addr = 32'h4;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midframe_rst_txd", {31'd0, txd}, 32'd1);
      check("midframe_rst_status", rd, 32'h0000_0002);
      tick(1);
      sel = 1'b0;
      tick(8);

      // BAUDDIV=0 gives one-cycle bits; CTRL bit1 only exists with the irq option
      bus_write(32'h8, 32'd0, SZ_W);
      bus_write(32'hC, 32'd3, SZ_W);
      bus_read(32'hC, v);
`ifdef UART_TX_IRQ_EN
      check("ctrl_irq_en_rw", v, 32'd3);
`else
      check("ctrl_bit1_reads_zero", v, 32'd1);
`endif
      bus_write(32'h0, 32'h3C, SZ_B);
      monitor_status(15);
      check("div0_busy_cycles", busy_n, 32'd10);
      check("div0_first_busy", first_busy, 32'd1);
      check("div0_start_txd", {31'd0, tx_s[1]}, 32'd0);
      check("div0_data0_txd", {31'd0, tx_s[2]}, 32'd0);
      check("div0_data2_txd", {31'd0, tx_s[4]}, 32'd1);
`ifdef UART_TX_IRQ_EN
      check("irq_low_at_idle_entry", {31'd0, irq_s[11]}, 32'd0);
      check("irq_high_after_idle", {31'd0, irq_s[12]}, 32'd1);
`endif
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
